sm4_key_sched: RTL and testbench

Iterative SM4 key-expansion engine. It accepts a 128-bit master key and produces the round-key schedule at one round per cycle into a local register file. It then serves the schedule to the SM4 round datapath as a valid/yumi stream, in forward order for encryption or reverse order for decryption. It sits beside the round datapath and reuses the static left-rotate shifter for the L' transform.

---
 rtl/sm4_pkg.sv | 67 ++++++
 rtl/roll_shifter.sv | 14 +
 rtl/sm4_tau.sv | 17 +
 rtl/sm4_key_sched.sv | 164 ++++++++++++++++
 tb/tb_sm4_key_sched.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/sm4_pkg.sv
// SM4 shared types, constants and S-box.
// Used by the key schedule and the round datapath.
package sm4_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] key_t;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY,
    STREAM
  } state_e;

  localparam word_t FK [4] = '{
    32'hA3B1BAC6, 32'h56AA3350,
    32'h677D9197, 32'hB27022DC
  };

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7,
    8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3,
    8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a,
    8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95,
    8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba,
    8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b,
    8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2,
    8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52,
    8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5,
    8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55,
    8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60,
    8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f,
    8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f,
    8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd,
    8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e,
    8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20,
    8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  // CK byte j of round i is ((4i+j)*7) mod 256; 8-bit wrap does the mod.
  function automatic word_t ck_word(input logic [5:0] i);
    word_t      w;
    logic [7:0] b;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      b = {i, 2'b00} + 8'(j);
      w[31-8*j -: 8] = 8'(b * 8'd7);
    end
    return w;
  endfunction

endpackage

// File: rtl/roll_shifter.sv
// Static left rotate by a fixed amount.
// Pure wiring; shift_p must be 1..width_p-1.
module roll_shifter #(
  parameter int width_p = 32,
  parameter int shift_p = 1
) (
  input  logic [width_p-1:0] i_data,
  output logic [width_p-1:0] o_data
);

  assign o_data = (i_data << shift_p)
                | (i_data >> (width_p - shift_p));

endmodule

// File: rtl/sm4_tau.sv
// SM4 tau: four parallel byte S-box lookups.
// Shared between key schedule and round datapath.
module sm4_tau
  import sm4_pkg::*;
(
  input  word_t i_data,
  output word_t o_data
);

  assign o_data = {
    SBOX[i_data[31:24]],
    SBOX[i_data[23:16]],
    SBOX[i_data[15:8]],
    SBOX[i_data[7:0]]
  };

endmodule

// File: rtl/sm4_key_sched.sv
// Iterative SM4 key expansion, one round per cycle,
// then valid/yumi replay of the schedule in either order.
module sm4_key_sched
  import sm4_pkg::*;
#(
  parameter int rounds_p    = 32,
  parameter int idx_width_p = $clog2(rounds_p)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   mk_v_i,
  input  logic [127:0]           mk_i,
  output logic                   mk_ready_o,
  input  logic                   start_v_i,
  input  logic                   decrypt_i,
  output logic                   start_ready_o,
  output logic                   rk_v_o,
  output logic [31:0]            rk_o,
  output logic [idx_width_p-1:0] rk_idx_o,
  input  logic                   rk_yumi_i,
  output logic                   sched_valid_o,
  output logic                   busy_o
);

  localparam logic [idx_width_p-1:0] LastIdx =
    idx_width_p'(rounds_p - 1);
  localparam logic [idx_width_p-1:0] One =
    idx_width_p'(1);

  state_e                 r_state;
  word_t                  r_k [4];
  word_t                  r_rf [rounds_p];
  logic [idx_width_p-1:0] r_ctr;
  logic [idx_width_p-1:0] r_idx;
  logic                   r_dec;
  logic                   r_sched_valid;
  logic                   r_rk_v;
  word_t                  r_rk;

  logic                   w_mk_acc;
  logic                   w_st_acc;
  logic                   w_yumi;
  logic                   w_last;
  logic [idx_width_p-1:0] w_start_idx;
  logic [idx_width_p-1:0] w_next_idx;
  word_t                  w_x;
  word_t                  w_t;
  word_t                  w_r13;
  word_t                  w_r23;
  word_t                  w_rk;

  assign mk_ready_o    = (r_state == IDLE)
                       | (r_state == READY);
  // Master key wins a same-cycle race with start.
  assign start_ready_o = (r_state == READY) & ~mk_v_i;
  assign busy_o        = (r_state == EXPAND)
                       | (r_state == STREAM);
  assign rk_v_o        = r_rk_v;
  assign rk_o          = r_rk;
  assign rk_idx_o      = r_idx;
  assign sched_valid_o = r_sched_valid;

  assign w_mk_acc    = mk_v_i & mk_ready_o;
  assign w_st_acc    = start_v_i & start_ready_o;
  assign w_yumi      = rk_yumi_i & r_rk_v;
  assign w_start_idx = decrypt_i ? LastIdx : '0;
  assign w_next_idx  = r_dec ? r_idx - One : r_idx + One;
  assign w_last      = r_dec ? (r_idx == '0)
                             : (r_idx == LastIdx);

  assign w_x = r_k[1] ^ r_k[2] ^ r_k[3]
             ^ ck_word(6'(r_ctr));

  sm4_tau u_tau (
    .i_data (w_x),
    .o_data (w_t)
  );

  roll_shifter #(.width_p(32), .shift_p(13)) u_rol13 (
    .i_data (w_t),
    .o_data (w_r13)
  );

  roll_shifter #(.width_p(32), .shift_p(23)) u_rol23 (
    .i_data (w_t),
    .o_data (w_r23)
  );

  assign w_rk = r_k[0] ^ w_t ^ w_r13 ^ w_r23;

  always_ff @(posedge clk_i) begin
    if (w_mk_acc) begin
      r_k[0] <= mk_i[127:96] ^ FK[0];
      r_k[1] <= mk_i[95:64]  ^ FK[1];
      r_k[2] <= mk_i[63:32]  ^ FK[2];
      r_k[3] <= mk_i[31:0]   ^ FK[3];
    end else if (r_state == EXPAND) begin
      r_k[0]      <= r_k[1];
      r_k[1]      <= r_k[2];
      r_k[2]      <= r_k[3];
      r_k[3]      <= w_rk;
      r_rf[r_ctr] <= w_rk;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state       <= IDLE;
      r_ctr         <= '0;
      r_idx         <= '0;
      r_dec         <= 1'b0;
      r_sched_valid <= 1'b0;
      r_rk_v        <= 1'b0;
      r_rk          <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_mk_acc) begin
            r_state <= EXPAND;
            r_ctr   <= '0;
          end
        end
        EXPAND: begin
          r_ctr <= r_ctr + One;
          if (r_ctr == LastIdx) begin
            r_state       <= READY;
            r_sched_valid <= 1'b1;
          end
        end
        READY: begin
          if (w_mk_acc) begin
            r_state       <= EXPAND;
            r_ctr         <= '0;
            r_sched_valid <= 1'b0;
          end else if (w_st_acc) begin
            r_state <= STREAM;
            r_dec   <= decrypt_i;
            r_idx   <= w_start_idx;
            r_rk    <= r_rf[w_start_idx];
            r_rk_v  <= 1'b1;
          end
        end
        STREAM: begin
          if (w_yumi) begin
            if (w_last) begin
              r_state <= READY;
              r_rk_v  <= 1'b0;
            end else begin
              r_idx <= w_next_idx;
              r_rk  <= r_rf[w_next_idx];
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  a_yumi_needs_valid: assert property (
    @(posedge clk_i) disable iff (reset_i)
    rk_yumi_i |-> rk_v_o
  );

endmodule

// File: tb/tb_sm4_key_sched.sv
// Directed bench for sm4_key_sched: standard key vector,
// both stream orders, back-pressure, races and resets.
module tb_sm4_key_sched;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         mk_v_i;
  logic [127:0] mk_i;
  logic         mk_ready_o;
  logic         start_v_i;
  logic         decrypt_i;
  logic         start_ready_o;
  logic         rk_v_o;
  logic [31:0]  rk_o;
  logic [4:0]   rk_idx_o;
  logic         rk_yumi_i;
  logic         sched_valid_o;
  logic         busy_o;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] gold [32];

  localparam logic [127:0] StdMk =
    128'h0123456789ABCDEFFEDCBA9876543210;

  always #5 clk_i = ~clk_i;

  sm4_key_sched dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .mk_v_i        (mk_v_i),
    .mk_i          (mk_i),
    .mk_ready_o    (mk_ready_o),
    .start_v_i     (start_v_i),
    .decrypt_i     (decrypt_i),
    .start_ready_o (start_ready_o),
    .rk_v_o        (rk_v_o),
    .rk_o          (rk_o),
    .rk_idx_o      (rk_idx_o),
    .rk_yumi_i     (rk_yumi_i),
    .sched_valid_o (sched_valid_o),
    .busy_o        (busy_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_mkr"}, mk_ready_o, 1);
    chk({tag, "_str"}, start_ready_o, 0);
    chk({tag, "_rkv"}, rk_v_o, 0);
    chk({tag, "_rk"}, rk_o, 0);
    chk({tag, "_idx"}, rk_idx_o, 0);
    chk({tag, "_sv"}, sched_valid_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Holds mk_v_i until accepted; returns just after the accept edge.
  task automatic send_key(input logic [127:0] k);
    int t = 0;
    mk_i   = k;
    mk_v_i = 1'b1;
    #1;
    while (!mk_ready_o && t < 100) begin
      step();
      t++;
    end
    chk("mk_wait", 32'(t < 100), 1);
    step();
    mk_v_i = 1'b0;
    chk("exp_busy", busy_o, 1);
    chk("exp_mkr", mk_ready_o, 0);
  endtask

  task automatic wait_expand();
    repeat (31) step();
    chk("sv_early", sched_valid_o, 0);
    chk("str_exp", start_ready_o, 0);
    step();
    chk("sv_rise", sched_valid_o, 1);
    chk("rdy_mkr", mk_ready_o, 1);
    chk("rdy_str", start_ready_o, 1);
    chk("rdy_busy", busy_o, 0);
  endtask

  task automatic run_stream(input logic dec,
                            input logic bp,
                            input logic cap);
    int         t = 0;
    int         n = 0;
    int         cyc = 0;
    logic       y;
    logic [4:0] ei;
    start_v_i = 1'b1;
    decrypt_i = dec;
    #1;
    while (!start_ready_o && t < 100) begin
      step();
      t++;
    end
    chk("st_wait", 32'(t < 100), 1);
    chk("st_lat0", rk_v_o, 0);
    step();
    start_v_i = 1'b0;
    decrypt_i = 1'b0;
    chk("st_lat1", rk_v_o, 1);
    chk("st_busy", busy_o, 1);
    while (n < 32 && cyc < 400) begin
      y  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      rk_yumi_i = y;
      ei = dec ? 5'(31 - n) : 5'(n);
      chk("rk_v", rk_v_o, 1);
      chk("idx", 32'(rk_idx_o), 32'(ei));
      if (cap) gold[ei] = rk_o;
      else     chk("rk", rk_o, gold[ei]);
      if (n == 0)  chk("first_idx", 32'(rk_idx_o), dec ? 31 : 0);
      step();
      if (y) n++;
      cyc++;
    end
    rk_yumi_i = 1'b0;
    chk("st_count", 32'(n), 32);
    chk("done_v", rk_v_o, 0);
    chk("done_str", start_ready_o, 1);
    chk("done_sv", sched_valid_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset_i   = 1'b1;
    mk_v_i    = 1'b0;
    mk_i      = '0;
    start_v_i = 1'b0;
    decrypt_i = 1'b0;
    rk_yumi_i = 1'b0;
    repeat (3) step();
    chk_rst("rst");
    reset_i = 1'b0;
    step();

    send_key(StdMk);
    wait_expand();

    run_stream(1'b0, 1'b0, 1'b1);
    chk("rk0", gold[0], 32'hF12186F9);
    chk("rk1", gold[1], 32'h41662B61);
    chk("rk31", gold[31], 32'h9124A012);

    // Reverse order must replay the same keys.
    run_stream(1'b1, 1'b0, 1'b0);
    run_stream(1'b0, 1'b1, 1'b0);
    run_stream(1'b0, 1'b0, 1'b0);
    run_stream(1'b0, 1'b0, 1'b0);

    mk_i      = StdMk;
    mk_v_i    = 1'b1;
    start_v_i = 1'b1;
    #1;
    chk("race_str", start_ready_o, 0);
    chk("race_mkr", mk_ready_o, 1);
    step();
    mk_v_i    = 1'b0;
    start_v_i = 1'b0;
    chk("race_busy", busy_o, 1);
    chk("race_sv", sched_valid_o, 0);
    chk("race_rkv", rk_v_o, 0);
    chk("race_mkr2", mk_ready_o, 0);
    wait_expand();
    run_stream(1'b1, 1'b1, 1'b0);

    send_key(StdMk);
    repeat (10) step();
    reset_i = 1'b1;
    step();
    chk_rst("rst_exp");
    reset_i = 1'b0;
    step();
    chk_rst("rst_exp2");

    send_key(StdMk);
    wait_expand();
    start_v_i = 1'b1;
    step();
    start_v_i = 1'b0;
    chk("ms_rkv", rk_v_o, 1);
    rk_yumi_i = 1'b1;
    repeat (5) step();
    rk_yumi_i = 1'b0;
    chk("ms_idx", 32'(rk_idx_o), 5);
    chk("ms_rk", rk_o, gold[5]);
    reset_i = 1'b1;
    step();
    chk_rst("rst_str");
    reset_i = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
